lutram_nr1w: RTL and testbench
==============================

Name: lutram_nr1w

Overview:
- Parametrised one-write / N-read distributed (LUT) RAM; the next-generation replacement for the fixed three-port async RAMs in fpga-support.
- Adds per-port count, selectable asynchronous or registered read, byte-enable writes, optional write-to-read forwarding and a hardware clear engine.
- The memory array is never reset directly, so Vivado and Libero still infer LUTRAM.
- Used for register files and small lookup tables inside the core.

Parameters:
ADDR_WIDTH, 10, address bits per port
DATA_DEPTH, 1024, number of words; must satisfy DATA_DEPTH <= 2**ADDR_WIDTH
DATA_WIDTH, 32, word width; must be a multiple of 8
NUM_RD_PORTS, 2, number of independent read ports; legal range 1..8
READ_MODE, 0, 0 = combinational read, 1 = read data registered (1-cycle latency)
BYPASS_EN, 1, 1 = same-cycle write to the read address is forwarded to the read data
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset deassertion

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset; asynchronous assert, active-low
ClrReq_SI  in  1  single-cycle pulse requesting a full array clear
Busy_SO  out  1  high while the clear engine runs
WrEn_SI  in  1  write enable
WrAddr_DI  in  ADDR_WIDTH  write address
WrBe_DI  in  DATA_WIDTH/8  byte enables
WrData_DI  in  DATA_WIDTH  write data
RdAddr_DI  in  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port i occupies slice i
RdData_DO  out  NUM_RD_PORTS*DATA_WIDTH  packed read data; port i occupies slice i

Behaviour:
- Reset and clock: one clock, Clk_CI. Reset Rst_RBI is asynchronous and active-low.
- Reset values: Busy_SO = CLEAR_ON_RESET. Registered RdData_DO = 0. FSM state = CLEAR if CLEAR_ON_RESET, else READY. Clear counter = 0. Array contents are not reset.
- FSM has two states, READY and CLEAR.
- READY -> CLEAR when ClrReq_SI = 1; counter is loaded with 0.
- In CLEAR, each rising edge writes 0 to mem[counter] and increments the counter.
- After the edge that writes DATA_DEPTH-1, the FSM returns to READY and Busy_SO drops. A clear therefore takes exactly DATA_DEPTH cycles.
- ClrReq_SI during CLEAR is ignored (no restart).
- Reset asserted mid-clear: asynchronous return to the reset state; the clear restarts from address 0.
- While Busy_SO = 1:
  - WrEn_SI is ignored; the user must hold off, and there is no backpressure.
  - RdData_DO reads 0 on every port: combinational 0 when READ_MODE = 0, register loads 0 when READ_MODE = 1.
- Write in READY: on a rising edge with WrEn_SI = 1 and WrAddr_DI < DATA_DEPTH, byte b of mem[WrAddr_DI] takes WrData_DI byte b where WrBe_DI[b] = 1; other bytes are kept.
- Out-of-range write addresses are dropped silently.
- Read data for port i: mem[RdAddr_i], or 0 if RdAddr_i >= DATA_DEPTH.
  - READ_MODE = 0: combinational, reflects the array pre-edge.
  - READ_MODE = 1: sampled into an output register on the rising edge; visible in the next cycle.
- Bypass (BYPASS_EN = 1, READY, WrEn_SI = 1, WrAddr_DI == RdAddr_i, address in range):
  - Port i sees the byte-merge of WrData_DI (enabled bytes) over the old word.
  - READ_MODE = 0: forwarded combinationally in the same cycle.
  - READ_MODE = 1: registered, visible next cycle.
- Bypass disabled (BYPASS_EN = 0): read-before-write; old data is returned.
- Multiple read ports may address the same word; all return identical data.
- Simultaneous ClrReq_SI and WrEn_SI in READY: the write commits on that edge, then the clear starts, so the word ends up 0.
- Simulation-only assertions: depth <= 2**ADDR_WIDTH; DATA_WIDTH % 8 == 0; NUM_RD_PORTS in 1..8; Busy_SO && WrEn_SI flagged as an error.

Decomposition:
- Package lutram_pkg holds:
  - state enum lutram_state_e {READY, CLEAR};
  - read-mode localparams RD_COMB = 0 and RD_REG = 1;
  - a function be_merge(old, new, be).
- Sub-module lutram_rd_port, instantiated NUM_RD_PORTS times by generate. Per port it implements range check, bypass compare/merge, busy zeroing and the optional output register.
- The array, write logic and clear FSM stay in the top module.

Test Plan:
- Reset clear (DEPTH = 16, CLEAR_ON_RESET = 1): release reset -> Busy_SO high for exactly 16 cycles, then low; all 16 addresses read 0.
- Byte-enable write (DATA_WIDTH = 32): write 0xAABBCCDD to addr 5 with BE = 0xF, then 0x11223344 with BE = 0x5 -> addr 5 reads 0xAA22CC44.
- Bypass (READ_MODE = 1):
  - BYPASS_EN = 1: addr 3 holds 0x0; write 0xDEADBEEF to addr 3 while port 1 reads addr 3 -> port 1 shows 0xDEADBEEF on the next cycle.
  - BYPASS_EN = 0: same stimulus -> 0x0.
- Read-mode latency (NUM_RD_PORTS = 4, READ_MODE = 0): the 4 ports address 0, 1, 1, 15 -> data appears the same cycle. With READ_MODE = 1 -> one cycle later; ports 1 and 2 are equal.
- Mid-clear reset: pulse ClrReq_SI, assert Rst_RBI at clear cycle 7, release -> the clear restarts and Busy_SO lasts DEPTH cycles from release; a write attempted during Busy_SO is discarded and its address reads 0 afterwards.
- Out-of-range access (DEPTH = 12, ADDR_WIDTH = 4): write 0x5 to addr 13 -> no array change; reading addr 13 -> 0.

Source files
------------

// File: rtl/lutram_pkg.sv
// ============================================================================
// lutram_pkg : shared types and helpers for the 1W/NR distributed RAM
// Revision   : 1.0
// ============================================================================
`default_nettype none

package lutram_pkg;

    typedef enum logic [0:0] {
        READY = 1'b0,
        CLEAR = 1'b1
    } lutram_state_e;

    localparam int RD_COMB = 0;
    localparam int RD_REG  = 1;

    // Byte-lane merge: the new byte wins only where its enable is set.
    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lutram_rd_port.sv
// ============================================================================
// lutram_rd_port : one read port - range check, write forwarding, busy
//                  zeroing and optional output register
// Revision       : 1.0
// ============================================================================
`default_nettype none

module lutram_rd_port
    import lutram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int READ_MODE  = 0,
    parameter int BYPASS_EN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_word,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int                  NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam bit                  BYP       = (BYPASS_EN != 0);

    logic                  in_range;
    logic                  hit;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] next_data;

    assign in_range = ({1'b0, rd_addr} < DEPTH_W);
    // wr_en arrives already qualified by the READY state
    assign hit      = BYP && wr_en && (wr_addr == rd_addr);

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
        assign merged[b*8 +: 8] = be_merge(mem_word[b*8 +: 8], wr_data[b*8 +: 8], wr_be[b]);
    end

    always_comb begin
        next_data = '0;
        if (!busy && in_range) begin
            next_data = hit ? merged : mem_word;
        end
    end

    if (READ_MODE == RD_REG) begin : g_reg
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= next_data;
            end
        end

        assign rd_data = data_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign rd_data        = next_data;
    end

endmodule

`default_nettype wire

// File: rtl/lutram_nr1w.sv
// ============================================================================
// lutram_nr1w : one-write / N-read distributed RAM with byte enables,
//               optional forwarding and a hardware clear engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lutram_nr1w
    import lutram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_DEPTH     = 1024,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_RD_PORTS   = 2,
    parameter int READ_MODE      = 0,
    parameter int BYPASS_EN      = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               Clk_CI,
    input  logic                               Rst_RBI,
    input  logic                               ClrReq_SI,
    output logic                               Busy_SO,
    input  logic                               WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]              WrAddr_DI,
    input  logic [DATA_WIDTH/8-1:0]            WrBe_DI,
    input  logic [DATA_WIDTH-1:0]              WrData_DI,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] RdAddr_DI,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] RdData_DO
);

    localparam int                  NUM_BYTES = DATA_WIDTH / 8;
    localparam int                  IDX_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DATA_DEPTH - 1);
    localparam lutram_state_e       RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    // No reset on the array so that it maps onto LUTRAM.
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    lutram_state_e    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             wr_ready;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;

    assign Busy_SO     = (state_q == CLEAR);
    assign wr_ready    = WrEn_SI && (state_q == READY);
    assign wr_in_range = ({1'b0, WrAddr_DI} < DEPTH_W);
    assign wr_idx      = WrAddr_DI[IDX_W-1:0];

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            READY: begin
                if (ClrReq_SI) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            default: state_d = READY;
        endcase
    end

    // A write coinciding with a clear request lands first; the clear wipes it later.
    always_ff @(posedge Clk_CI) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (WrEn_SI && wr_in_range) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (WrBe_DI[b]) begin
                    mem[wr_idx][b*8 +: 8] <= WrData_DI[b*8 +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd_port
        logic [ADDR_WIDTH-1:0] port_addr;
        logic [DATA_WIDTH-1:0] port_word;

        assign port_addr = RdAddr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_word = mem[port_addr[IDX_W-1:0]];

        lutram_rd_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_DEPTH (DATA_DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .READ_MODE  (READ_MODE),
            .BYPASS_EN  (BYPASS_EN)
        ) u_rd_port (
            .clk      (Clk_CI),
            .rst_n    (Rst_RBI),
            .busy     (Busy_SO),
            .wr_en    (wr_ready),
            .wr_addr  (WrAddr_DI),
            .wr_be    (WrBe_DI),
            .wr_data  (WrData_DI),
            .rd_addr  (port_addr),
            .mem_word (port_word),
            .rd_data  (RdData_DO[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifndef SYNTHESIS
    assert property (@(posedge Clk_CI) disable iff (!Rst_RBI) !(Busy_SO && WrEn_SI))
        else $error("lutram_nr1w: write issued while the clear engine is busy");

    assert property (@(posedge Clk_CI)
        (DATA_DEPTH <= 2**ADDR_WIDTH) && (DATA_WIDTH % 8 == 0) &&
        (NUM_RD_PORTS >= 1) && (NUM_RD_PORTS <= 8))
        else $error("lutram_nr1w: illegal parameter combination");
`endif

endmodule

`default_nettype wire

// File: tb/tb_lutram_nr1w.sv
// ============================================================================
// tb_lutram_nr1w : directed bench over three configurations of lutram_nr1w
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_lutram_nr1w;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NP = 4;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b1;
    logic           clr_req = 1'b0;
    logic           wr_en   = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [3:0]     wr_be   = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [NP*AW-1:0] rd_addr = '0;
    logic [NP*DW-1:0] rd_a, rd_b, rd_c;
    logic           busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: depth 16, combinational read, forwarding on
    lutram_nr1w #(.ADDR_WIDTH(AW), .DATA_DEPTH(16), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP),
                  .READ_MODE(0), .BYPASS_EN(1), .CLEAR_ON_RESET(1)) u_a (
        .Clk_CI(clk), .Rst_RBI(rst_n), .ClrReq_SI(clr_req), .Busy_SO(busy_a),
        .WrEn_SI(wr_en), .WrAddr_DI(wr_addr), .WrBe_DI(wr_be), .WrData_DI(wr_data),
        .RdAddr_DI(rd_addr), .RdData_DO(rd_a));

    // B: depth 16, registered read, forwarding on
    lutram_nr1w #(.ADDR_WIDTH(AW), .DATA_DEPTH(16), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP),
                  .READ_MODE(1), .BYPASS_EN(1), .CLEAR_ON_RESET(1)) u_b (
        .Clk_CI(clk), .Rst_RBI(rst_n), .ClrReq_SI(clr_req), .Busy_SO(busy_b),
        .WrEn_SI(wr_en), .WrAddr_DI(wr_addr), .WrBe_DI(wr_be), .WrData_DI(wr_data),
        .RdAddr_DI(rd_addr), .RdData_DO(rd_b));

    // C: depth 12, registered read, forwarding off
    lutram_nr1w #(.ADDR_WIDTH(AW), .DATA_DEPTH(12), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP),
                  .READ_MODE(1), .BYPASS_EN(0), .CLEAR_ON_RESET(1)) u_c (
        .Clk_CI(clk), .Rst_RBI(rst_n), .ClrReq_SI(clr_req), .Busy_SO(busy_c),
        .WrEn_SI(wr_en), .WrAddr_DI(wr_addr), .WrBe_DI(wr_be), .WrData_DI(wr_data),
        .RdAddr_DI(rd_addr), .RdData_DO(rd_c));

    typedef struct {
        logic         we;
        logic [3:0]   wa;
        logic [3:0]   be;
        logic [31:0]  wd;
        logic [15:0]  ra;
        logic [127:0] exp_a;   // A same cycle, B one cycle later
        logic [127:0] exp_c;   // C one cycle later
    } vec_t;

    vec_t vecs [9];

    function automatic logic [15:0] ra4(input int p0, input int p1, input int p2, input int p3);
        return {4'(p3), 4'(p2), 4'(p1), 4'(p0)};
    endfunction

    function automatic logic [127:0] d4(input logic [31:0] p0, input logic [31:0] p1,
                                        input logic [31:0] p2, input logic [31:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_busy(output int na, output int nb, output int nc);
        na = 0; nb = 0; nc = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (busy_c) nc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic [15:0] ra);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_addr = ra;
    endtask

    initial begin
        int na, nb, nc;

        vecs[0] = '{1'b1, 4'd5,  4'hF, 32'hAABBCCDD, ra4(5, 5, 0, 13),
                    d4(32'hAABBCCDD, 32'hAABBCCDD, 0, 0), d4(0, 0, 0, 0)};
        vecs[1] = '{1'b1, 4'd5,  4'h5, 32'h11223344, ra4(5, 5, 5, 5),
                    d4(32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44),
                    d4(32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD)};
        vecs[2] = '{1'b0, 4'd0,  4'h0, 32'h0, ra4(5, 5, 5, 5),
                    d4(32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44),
                    d4(32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44)};
        vecs[3] = '{1'b1, 4'd3,  4'hF, 32'hDEADBEEF, ra4(0, 3, 3, 5),
                    d4(0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hAA22CC44),
                    d4(0, 0, 0, 32'hAA22CC44)};
        vecs[4] = '{1'b0, 4'd0,  4'h0, 32'h0, ra4(0, 3, 5, 3),
                    d4(0, 32'hDEADBEEF, 32'hAA22CC44, 32'hDEADBEEF),
                    d4(0, 32'hDEADBEEF, 32'hAA22CC44, 32'hDEADBEEF)};
        vecs[5] = '{1'b1, 4'd13, 4'hF, 32'h00000005, ra4(13, 13, 3, 0),
                    d4(32'h5, 32'h5, 32'hDEADBEEF, 0), d4(0, 0, 32'hDEADBEEF, 0)};
        vecs[6] = '{1'b0, 4'd0,  4'h0, 32'h0, ra4(13, 12, 11, 13),
                    d4(32'h5, 0, 0, 32'h5), d4(0, 0, 0, 0)};
        vecs[7] = '{1'b1, 4'd0,  4'h8, 32'h12345678, ra4(0, 0, 15, 1),
                    d4(32'h12000000, 32'h12000000, 0, 0), d4(0, 0, 0, 0)};
        vecs[8] = '{1'b1, 4'd1,  4'h3, 32'hCAFEF00D, ra4(1, 1, 1, 14),
                    d4(32'h0000F00D, 32'h0000F00D, 32'h0000F00D, 0), d4(0, 0, 0, 0)};

        // Reset values, asserted asynchronously
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_a", 128'(busy_a), 128'd1);
        check("rst_busy_c", 128'(busy_c), 128'd1);
        check("rst_rd_a",   rd_a, '0);
        check("rst_rd_b",   rd_b, '0);
        check("rst_rd_c",   rd_c, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        count_busy(na, nb, nc);
        check("reset_clear_len_a", 128'(na), 128'd16);
        check("reset_clear_len_b", 128'(nb), 128'd16);
        check("reset_clear_len_c", 128'(nc), 128'd12);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 4'd0, 4'h0, 32'h0, ra4(4*k, 4*k+1, 4*k+2, 4*k+3));
            #1 check($sformatf("cleared_a_%0d", k), rd_a, '0);
            @(posedge clk); #1;
            check($sformatf("cleared_b_%0d", k), rd_b, '0);
            check($sformatf("cleared_c_%0d", k), rd_c, '0);
        end

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].ra);
            #1 check($sformatf("vec%0d_a", i), rd_a, vecs[i].exp_a);
            @(posedge clk); #1;
            check($sformatf("vec%0d_b", i), rd_b, vecs[i].exp_a);
            check($sformatf("vec%0d_c", i), rd_c, vecs[i].exp_c);
        end

        // Read latency: A follows the address immediately, B only after the edge
        @(negedge clk);
        drive(1'b0, 4'd0, 4'h0, 32'h0, ra4(0, 1, 1, 15));
        #1;
        check("lat_a_same_cycle", rd_a, d4(32'h12000000, 32'hF00D, 32'hF00D, 0));
        check("lat_b_held",       rd_b, d4(32'hF00D, 32'hF00D, 32'hF00D, 0));
        @(posedge clk); #1;
        check("lat_b_next_cycle", rd_b, d4(32'h12000000, 32'hF00D, 32'hF00D, 0));
        check("lat_c_next_cycle", rd_c, d4(32'h12000000, 32'hF00D, 32'hF00D, 0));

        // Write and clear request on the same edge, then reset in the middle of the clear
        @(negedge clk);
        drive(1'b1, 4'd2, 4'hF, 32'h77777777, ra4(2, 0, 5, 13));
        clr_req = 1'b1;
        #1 check("clrwr_a_fwd", rd_a, d4(32'h77777777, 32'h12000000, 32'hAA22CC44, 32'h5));
        @(posedge clk); #1;
        check("clr_busy_a", 128'(busy_a), 128'd1);
        check("clrwr_b_fwd", rd_b, d4(32'h77777777, 32'h12000000, 32'hAA22CC44, 32'h5));
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b0;
        #1 check("busy_zero_a", rd_a, '0);
        @(posedge clk); #1;
        check("busy_zero_b", rd_b, '0);
        check("busy_zero_c", rd_c, '0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midclr_rst_busy_a", 128'(busy_a), 128'd1);
        check("midclr_rst_rd_b",   rd_b, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        count_busy(na, nb, nc);
        check("restart_clear_len_a", 128'(na), 128'd16);
        check("restart_clear_len_b", 128'(nb), 128'd16);
        check("restart_clear_len_c", 128'(nc), 128'd12);

        @(negedge clk);
        drive(1'b0, 4'd0, 4'h0, 32'h0, ra4(2, 0, 5, 13));
        #1 check("after_clear_a", rd_a, '0);
        @(posedge clk); #1;
        check("after_clear_b", rd_b, '0);
        check("after_clear_c", rd_c, '0);

        // Writes are accepted again once the clear has finished
        @(negedge clk);
        drive(1'b1, 4'd9, 4'hF, 32'h0BADF00D, ra4(9, 9, 2, 5));
        #1 check("post_wr_a_fwd", rd_a, d4(32'h0BADF00D, 32'h0BADF00D, 0, 0));
        @(posedge clk); #1;
        check("post_wr_b_fwd", rd_b, d4(32'h0BADF00D, 32'h0BADF00D, 0, 0));
        check("post_wr_c_old", rd_c, d4(0, 0, 0, 0));
        @(negedge clk);
        wr_en = 1'b0;
        #1 check("post_wr_a_stored", rd_a, d4(32'h0BADF00D, 32'h0BADF00D, 0, 0));
        @(posedge clk); #1;
        check("post_wr_c_stored", rd_c, d4(32'h0BADF00D, 32'h0BADF00D, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
